// File: rtl/tx_packetizer.sv
// Serializes an eight-field packet onto a word stream after an LFSR-randomized,
// carrier-sense-gated backoff; discards untransmittable types and busy-channel timeouts.
`timescale 1ns/1ps
module tx_packetizer #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [2:0]            rPacketType,
    input  logic [WORD_WIDTH-1:0] rSourceID,
    input  logic [WORD_WIDTH-1:0] rDestinationID,
    input  logic [WORD_WIDTH-1:0] rEnergyLeft,
    input  logic [WORD_WIDTH-1:0] rQValue,
    input  logic [WORD_WIDTH-1:0] rSourceHops,
    input  logic [WORD_WIDTH-1:0] rChosenCH,
    input  logic [WORD_WIDTH-1:0] rHopsFromCH,
    input  logic                  chan_busy,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_sop,
    output logic                  tx_eop,
    output logic                  tx_done,
    output logic                  tx_drop
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {StIdle, StBackoff, StSend, StDone} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              lfsr_q, lfsr_d;
    logic [4:0]              backoff_q, backoff_d;
    logic [WaitW-1:0]        wait_q, wait_d;
    logic [2:0]              idx_q, idx_d;
    logic                    drop_q, drop_d;
    logic [WORD_WIDTH-1:0]   field_q [8];
    logic                    accept;
    logic                    bad_type;

    assign accept   = pkt_valid && (state_q == StIdle);
    assign bad_type = (rPacketType == 3'b111) || (rPacketType == 3'b001);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StIdle;
            lfsr_q    <= 8'hB5;
            backoff_q <= '0;
            wait_q    <= '0;
            idx_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            backoff_q <= backoff_d;
            wait_q    <= wait_d;
            idx_q     <= idx_d;
            drop_q    <= drop_d;
        end
    end

    // Fields are captured for every accepted packet, including discarded types.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 8; i++) begin
                field_q[i] <= '0;
            end
        end else if (accept) begin
            field_q[0] <= WORD_WIDTH'(rPacketType);
            field_q[1] <= rSourceID;
            field_q[2] <= rDestinationID;
            field_q[3] <= rEnergyLeft;
            field_q[4] <= rQValue;
            field_q[5] <= rSourceHops;
            field_q[6] <= rChosenCH;
            field_q[7] <= rHopsFromCH;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        backoff_d = backoff_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        drop_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (pkt_valid) begin
                    if (bad_type) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d   = StBackoff;
                        backoff_d = {1'b0, lfsr_q[3:0]} + 5'd1;
                        wait_d    = '0;
                    end
                end
            end
            StBackoff: begin
                if (chan_busy) begin
                    if (wait_q == WaitLast) begin
                        state_d = StIdle;
                        drop_d  = 1'b1;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end else if (backoff_q == 5'd1) begin
                    state_d   = StSend;
                    backoff_d = '0;
                    idx_d     = '0;
                end else begin
                    backoff_d = backoff_q - 5'd1;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pkt_ready = (state_q == StIdle);
        tx_valid  = (state_q == StSend);
        tx_data   = tx_valid ? field_q[idx_q] : '0;
        tx_sop    = tx_valid && (idx_q == 3'd0);
        tx_eop    = tx_valid && (idx_q == 3'd7);
        tx_done   = (state_q == StDone);
        tx_drop   = drop_q;
    end

endmodule

// File: tb/tb_tx_packetizer.sv
// Directed and randomized bench for tx_packetizer; expectations come from a
// cycle-level timing model of backoff, word order and handshakes.
`timescale 1ns/1ps
module tb_tx_packetizer;

    localparam int WW = 16;

    logic          clk = 1'b0;
    logic          nrst;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [2:0]    p_type;
    logic [WW-1:0] p_src, p_dst, p_energy, p_q, p_shops, p_ch, p_chhops;
    logic          chan_busy;
    logic [WW-1:0] tx_data;
    logic          tx_valid, tx_ready, tx_sop, tx_eop, tx_done, tx_drop;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc;

    tx_packetizer #(
        .WORD_WIDTH (WW),
        .MAX_WAIT   (255)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .rPacketType    (p_type),
        .rSourceID      (p_src),
        .rDestinationID (p_dst),
        .rEnergyLeft    (p_energy),
        .rQValue        (p_q),
        .rSourceHops    (p_shops),
        .rChosenCH      (p_ch),
        .rHopsFromCH    (p_chhops),
        .chan_busy      (chan_busy),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_sop         (tx_sop),
        .tx_eop         (tx_eop),
        .tx_done        (tx_done),
        .tx_drop        (tx_drop)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release: the number of LFSR advances so far.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] lfsr_at(input int unsigned n);
        logic [7:0] l = 8'hB5;
        for (int unsigned i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_fields();
        p_src    = WW'($urandom);
        p_dst    = WW'($urandom);
        p_energy = WW'($urandom);
        p_q      = WW'($urandom);
        p_shops  = WW'($urandom);
        p_ch     = WW'($urandom);
        p_chhops = WW'($urandom);
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        pkt_valid = 1'b0;
        chan_busy = 1'b0;
        tx_ready  = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // Called at a negedge; returns at a negedge with the block idle.
    task automatic send_pkt(input logic [2:0] typ, input int busy_start, input int busy_len,
                            input bit bp, input bit scramble, input int rst_word);
        logic [WW-1:0] w_exp [8];
        logic [7:0]    l;
        int            bo, bs, first_t, w, send_cycles, seen;
        bit            finished;

        check("accept_ready", 32'(pkt_ready), 32'd1);
        randomize_fields();
        p_type = typ;
        w_exp[0] = WW'(typ);
        w_exp[1] = p_src;    w_exp[2] = p_dst; w_exp[3] = p_energy; w_exp[4] = p_q;
        w_exp[5] = p_shops;  w_exp[6] = p_ch;  w_exp[7] = p_chhops;
        pkt_valid = 1'b1;
        chan_busy = 1'b0;
        tx_ready  = 1'b0;
        l  = lfsr_at(cyc);
        bo = int'(l[3:0]) + 1;
        @(negedge clk);
        pkt_valid = 1'b0;

        if (typ == 3'b111 || typ == 3'b001) begin
            check("discard_drop", 32'(tx_drop), 32'd1);
            check("discard_valid", 32'(tx_valid), 32'd0);
            check("discard_ready", 32'(pkt_ready), 32'd1);
            @(negedge clk);
            check("discard_drop_end", 32'(tx_drop), 32'd0);
            check("discard_valid_end", 32'(tx_valid), 32'd0);
            return;
        end

        bs = (busy_start > bo) ? bo : busy_start;
        if (bs < 1) bs = 1;
        first_t = bo + 1 + busy_len;
        w = 0;
        send_cycles = 0;
        seen = -1;
        finished = 1'b0;
        for (int t = 1; t < first_t + 40 && !finished; t++) begin
            chan_busy = (busy_len > 0 && t >= bs && t < bs + busy_len);
            if (t < first_t) begin
                check("backoff_valid", 32'(tx_valid), 32'd0);
                check("backoff_ready", 32'(pkt_ready), 32'd0);
                check("backoff_drop", 32'(tx_drop), 32'd0);
            end else if (w < 8) begin
                if (tx_valid && seen < 0) seen = t;
                check("send_valid", 32'(tx_valid), 32'd1);
                check($sformatf("send_word%0d", w), 32'(tx_data), 32'(w_exp[w]));
                check("send_sop", 32'(tx_sop), 32'(w == 0));
                check("send_eop", 32'(tx_eop), 32'(w == 7));
                check("send_drop", 32'(tx_drop), 32'd0);
                if (w == rst_word) begin
                    nrst = 1'b0;
                    #1;
                    check("rst_ready", 32'(pkt_ready), 32'd1);
                    check("rst_valid", 32'(tx_valid), 32'd0);
                    check("rst_data", 32'(tx_data), 32'd0);
                    check("rst_sop_eop", 32'({tx_sop, tx_eop}), 32'd0);
                    check("rst_done_drop", 32'({tx_done, tx_drop}), 32'd0);
                    pkt_valid = 1'b0;
                    chan_busy = 1'b0;
                    tx_ready  = 1'b0;
                    @(negedge clk);
                    nrst = 1'b1;
                    @(negedge clk);
                    check("rst_after_done_drop", 32'({tx_done, tx_drop}), 32'd0);
                    check("rst_after_ready", 32'(pkt_ready), 32'd1);
                    finished = 1'b1;
                end else begin
                    if (scramble) begin
                        chan_busy = 1'($urandom);
                        pkt_valid = 1'($urandom);
                        p_type    = 3'($urandom);
                        randomize_fields();
                    end
                    tx_ready = bp ? send_cycles[0] : 1'b1;
                    send_cycles++;
                    if (tx_ready) w++;
                end
            end else begin
                check("done_pulse", 32'(tx_done), 32'd1);
                check("done_valid", 32'(tx_valid), 32'd0);
                pkt_valid = 1'b0;
                chan_busy = 1'b0;
                tx_ready  = 1'b0;
                @(negedge clk);
                check("done_end", 32'(tx_done), 32'd0);
                check("done_idle_ready", 32'(pkt_ready), 32'd1);
                finished = 1'b1;
            end
            if (!finished) @(negedge clk);
        end
        check("pkt_finished", 32'(finished), 32'd1);
        check("first_valid_cycle", 32'(seen), 32'(first_t));
        if (bp && rst_word < 0) check("bp_send_cycles", 32'(send_cycles), 32'd16);
    endtask

    initial begin
        logic [2:0] typ;
        int         r;

        nrst = 1'b0;
        pkt_valid = 1'b0;
        chan_busy = 1'b0;
        tx_ready  = 1'b0;
        p_type    = 3'd0;
        randomize_fields();
        #1;
        check("reset_ready", 32'(pkt_ready), 32'd1);
        check("reset_outputs", 32'({tx_valid, tx_sop, tx_eop, tx_done, tx_drop}), 32'd0);
        check("reset_data", 32'(tx_data), 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Basic send on the first edge after reset: backoff of 6.
        send_pkt(3'b000, 1, 0, 1'b0, 1'b0, -1);

        // Frozen backoff: 10 busy cycles starting mid-backoff.
        apply_reset();
        send_pkt(3'b000, 3, 10, 1'b0, 1'b0, -1);

        // Busy timeout.
        randomize_fields();
        p_type = 3'b011;
        pkt_valid = 1'b1;
        chan_busy = 1'b0;
        @(negedge clk);
        pkt_valid = 1'b0;
        for (int t = 1; t <= 255; t++) begin
            chan_busy = 1'b1;
            check("timeout_quiet", 32'({tx_valid, tx_drop}), 32'd0);
            @(negedge clk);
        end
        check("timeout_drop", 32'(tx_drop), 32'd1);
        check("timeout_valid", 32'(tx_valid), 32'd0);
        check("timeout_ready", 32'(pkt_ready), 32'd1);
        chan_busy = 1'b0;
        @(negedge clk);
        check("timeout_drop_end", 32'(tx_drop), 32'd0);
        check("timeout_ready_next", 32'(pkt_ready), 32'd1);

        // Discarded types.
        send_pkt(3'b111, 1, 0, 1'b0, 1'b0, -1);
        send_pkt(3'b001, 1, 0, 1'b0, 1'b0, -1);

        // Backpressure with inputs scrambled during the packet.
        send_pkt(3'b010, 1, 0, 1'b1, 1'b1, -1);

        // Reset during word 3, then a clean packet.
        send_pkt(3'b100, 1, 0, 1'b0, 1'b0, 3);
        send_pkt(3'b101, 1, 0, 1'b0, 1'b0, -1);

        // Randomized packets.
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r = $urandom_range(0, 7);
            typ = 3'(r);
            send_pkt(typ, $urandom_range(1, 16), $urandom_range(0, 20),
                     1'($urandom), 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
